scpu_mem_system: RTL and testbench

//  Memory-side counterpart of the single-cycle CPU core: instruction ROM and data RAM.

---
 rtl/scpu_mem_pkg.sv | 16 +
 rtl/scpu_word_ram.sv | 28 ++
 rtl/scpu_mem_system.sv | 186 ++++++++++++++++++
 tb/tb_scpu_mem_system.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/scpu_mem_pkg.sv
// Shared types and constants for the single-cycle CPU memory system.
// The optional LED register (SCPU_MMIO_LED_EN) uses MMIO_LED_ADDR below.
package scpu_mem_pkg;

    localparam int WORD_W = 32;

    // Byte address of the memory-mapped LED register.
    localparam logic [31:0] MMIO_LED_ADDR = 32'hE000_0000;

    // Boot state: LOAD while the image streams in, RUN once the CPU is released.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/scpu_word_ram.sv
// Word-wide RAM with combinational read and synchronous write.
// Contents are never reset, so the image survives a reset of the system.
module scpu_word_ram
    import scpu_mem_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1<<AW)-1];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero-latency read so the CPU sees instruction/load data in the same cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/scpu_mem_system.sv
// Instruction ROM + data RAM for the single-cycle CPU, with a boot loader
// that fills both memories from a valid/ready stream while the CPU is held
// in reset. Optional feature: define SCPU_MMIO_LED_EN to add a 16-bit LED
// register mapped at MMIO_LED_ADDR.
module scpu_mem_system
    import scpu_mem_pkg::*;
#(
    parameter int IMEM_AW = 7,
    parameter int DMEM_AW = 6,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              cpu_reset,
    input  logic [31:0]       PC_out,
    output logic [31:0]       inst_in,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    input  logic              MemW,
    output logic [31:0]       Data_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              boot_ovf,
    output logic              addr_err,
    output logic [CNT_W-1:0]  st_cnt
`ifdef SCPU_MMIO_LED_EN
    ,
    output logic [15:0]       led
`endif
);

    state_t state;

    // Load pointers carry one extra bit: the MSB set means the segment is full.
    logic [IMEM_AW:0] ip;
    logic [DMEM_AW:0] dp;

    logic              beat;
    logic              running;
    logic              imem_full;
    logic              dmem_full;
    logic              pc_ok;
    logic              data_ok;
    logic              st_dmem;
    logic              st_led;
    logic              st_bad;
    logic              st_commit;

    logic              imem_we;
    logic              dmem_we;
    logic [DMEM_AW-1:0] dmem_waddr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] dmem_rdata;

    assign beat      = ld_valid & ld_ready;
    assign running   = (state == RUN);
    assign imem_full = ip[IMEM_AW];
    assign dmem_full = dp[DMEM_AW];

    // Word-aligned and inside the segment: every upper address bit must be zero.
    assign pc_ok   = (PC_out[1:0] == 2'b00)   && (PC_out[31:IMEM_AW+2] == '0);
    assign data_ok = (Addr_out[1:0] == 2'b00) && (Addr_out[31:DMEM_AW+2] == '0);

`ifdef SCPU_MMIO_LED_EN
    logic is_led;
    assign is_led = (Addr_out == MMIO_LED_ADDR);
    assign st_led = running & MemW & is_led;
    assign st_bad = running & MemW & ~data_ok & ~is_led;
`else
    assign st_led = 1'b0;
    assign st_bad = running & MemW & ~data_ok;
`endif

    // CPU stores only take effect in RUN; while loading the CPU is in reset.
    assign st_dmem   = running & MemW & data_ok;
    assign st_commit = st_dmem | st_led;

    // IMEM is written only by the loader; beats past the end are dropped.
    assign imem_we = beat & ~ld_sel & ~imem_full;

    // DMEM write port is shared: loader in LOAD, CPU stores in RUN.
    assign dmem_we    = (beat & ld_sel & ~dmem_full) | st_dmem;
    assign dmem_waddr = running ? Addr_out[DMEM_AW+1:2] : dp[DMEM_AW-1:0];
    assign dmem_wdata = running ? Data_out : ld_data;

    scpu_word_ram #(.AW(IMEM_AW)) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (ip[IMEM_AW-1:0]),
        .wdata (ld_data),
        .raddr (PC_out[IMEM_AW+1:2]),
        .rdata (imem_rdata)
    );

    scpu_word_ram #(.AW(DMEM_AW)) u_dmem (
        .clk   (clk),
        .we    (dmem_we),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .raddr (Addr_out[DMEM_AW+1:2]),
        .rdata (dmem_rdata)
    );

    // Boot FSM: advance pointers per beat, flag overflow, release the CPU after ld_last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b1;
            ip        <= '0;
            dp        <= '0;
            boot_ovf  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (beat) begin
                        if (!ld_sel) begin
                            if (imem_full) boot_ovf <= 1'b1;
                            else           ip       <= ip + 1'b1;
                        end else begin
                            if (dmem_full) boot_ovf <= 1'b1;
                            else           dp       <= dp + 1'b1;
                        end
                        if (ld_last) begin
                            state     <= RUN;
                            cpu_reset <= 1'b0;
                            ld_ready  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Left only through reset.
                    state <= RUN;
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Sticky access-error flag; PC is only checked while the CPU is running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if ((running && !pc_ok) || st_bad) begin
            addr_err <= 1'b1;
        end
    end

    // Saturating count of stores that actually landed somewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_cnt <= '0;
        end else if (st_commit && (st_cnt != {CNT_W{1'b1}})) begin
            st_cnt <= st_cnt + 1'b1;
        end
    end

    // Fetch: out-of-range or misaligned PC, or any fetch while loading, yields a nop.
    assign inst_in = (running && pc_ok) ? imem_rdata : '0;

`ifdef SCPU_MMIO_LED_EN
    // LED register takes the low half of the stored word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led <= 16'h0000;
        end else if (st_led) begin
            led <= Data_out[15:0];
        end
    end

    // Load mux: DMEM word, LED register, or zero.
    always_comb begin
        Data_in = '0;
        if (running && data_ok)     Data_in = dmem_rdata;
        else if (running && is_led) Data_in = {16'h0000, led};
    end
`else
    // Load mux: DMEM word, or zero when loading / out of range.
    assign Data_in = (running && data_ok) ? dmem_rdata : '0;
`endif

endmodule

// File: tb/tb_scpu_mem_system.sv
// Directed self-checking bench for scpu_mem_system (default parameters).
// Covers SCPU_MMIO_LED_EN when that macro is defined for the build.
module tb_scpu_mem_system;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_reset;
    logic [31:0] PC_out = '0;
    logic [31:0] inst_in;
    logic [31:0] Addr_out = '0;
    logic [31:0] Data_out = '0;
    logic        MemW = 1'b0;
    logic [31:0] Data_in;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic        ld_sel = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        boot_ovf;
    logic        addr_err;
    logic [15:0] st_cnt;
`ifdef SCPU_MMIO_LED_EN
    logic [15:0] led;
`endif

    int checks = 0;
    int failures = 0;

    scpu_mem_system dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_reset (cpu_reset),
        .PC_out    (PC_out),
        .inst_in   (inst_in),
        .Addr_out  (Addr_out),
        .Data_out  (Data_out),
        .MemW      (MemW),
        .Data_in   (Data_in),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .boot_ovf  (boot_ovf),
        .addr_err  (addr_err),
        .st_cnt    (st_cnt)
`ifdef SCPU_MMIO_LED_EN
        ,
        .led       (led)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-16s observed=%h expected=%h ok", tag, obs, exp);
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic beat(input logic sel, input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        $display("beat sel=%0d data=%h last=%0d", sel, data, last);
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("rst_ld_ready",  {31'b0, ld_ready},  32'd1);
        chk("rst_boot_ovf",  {31'b0, boot_ovf},  32'd0);
        chk("rst_addr_err",  {31'b0, addr_err},  32'd0);
        chk("rst_st_cnt",    {16'b0, st_cnt},    32'd0);
        chk("load_inst_zero", inst_in,           32'd0);
        chk("load_data_zero", Data_in,           32'd0);

        // ---- boot image ----
        beat(1'b0, 32'h0800_0008, 1'b0);
        beat(1'b0, 32'h0000_0827, 1'b0);
        beat(1'b0, 32'h0021_1820, 1'b0);
        // ld_last without ld_valid must be ignored
        ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        chk("last_no_valid", {31'b0, ld_ready}, 32'd1);
        chk("cpu_rst_held",  {31'b0, cpu_reset}, 32'd1);
        beat(1'b1, 32'h0000_0001, 1'b1);
        chk("boot_cpu_reset", {31'b0, cpu_reset}, 32'd0);
        chk("boot_ld_ready",  {31'b0, ld_ready},  32'd0);
        PC_out = 32'h0; #1;
        chk("fetch_pc0", inst_in, 32'h0800_0008);
        PC_out = 32'h4; #1;
        chk("fetch_pc4", inst_in, 32'h0000_0827);
        PC_out = 32'h8; #1;
        chk("fetch_pc8", inst_in, 32'h0021_1820);
        PC_out = 32'h0;
        Addr_out = 32'h0; #1;
        chk("load_a0", Data_in, 32'h0000_0001);

        // ---- store / load ----
        Addr_out = 32'h4; Data_out = 32'hDEAD_BEEF; MemW = 1'b1;
        tick();
        MemW = 1'b0; #1;
        chk("store1_visible", Data_in, 32'hDEAD_BEEF);
        chk("store1_cnt", {16'b0, st_cnt}, 32'd1);
        Data_out = 32'hCAFE_F00D; MemW = 1'b1; #1;
        chk("store2_old", Data_in, 32'hDEAD_BEEF);
        tick();
        MemW = 1'b0; #1;
        chk("store2_new", Data_in, 32'hCAFE_F00D);
        chk("store2_cnt", {16'b0, st_cnt}, 32'd2);
        chk("no_err_yet", {31'b0, addr_err}, 32'd0);

        // ---- bounds ----
        PC_out = 32'h0000_0200; #1;
        chk("pc_oor_nop", inst_in, 32'd0);
        tick();
        chk("pc_oor_err", {31'b0, addr_err}, 32'd1);
        PC_out = 32'h0000_0002; #1;
        chk("pc_mis_nop", inst_in, 32'd0);
        PC_out = 32'h0;
        Addr_out = 32'h6; Data_out = 32'h1234_5678; MemW = 1'b1; #1;
        chk("ld_mis_zero", Data_in, 32'd0);
        tick();
        MemW = 1'b0;
        Addr_out = 32'h4; #1;
        chk("st_mis_cnt", {16'b0, st_cnt}, 32'd2);
        chk("st_mis_err", {31'b0, addr_err}, 32'd1);
        chk("st_mis_nowr", Data_in, 32'hCAFE_F00D);

        // ---- reset mid-boot ----
        do_reset();
        chk("rst2_addr_err", {31'b0, addr_err}, 32'd0);
        chk("rst2_st_cnt", {16'b0, st_cnt}, 32'd0);
        beat(1'b0, 32'h1111_1111, 1'b0);
        beat(1'b0, 32'h2222_2222, 1'b0);
        do_reset();
        chk("mid_cpu_reset", {31'b0, cpu_reset}, 32'd1);
        // CPU store attempt while loading must not touch DMEM
        Addr_out = 32'h0; Data_out = 32'h0000_0BAD; MemW = 1'b1;
        tick();
        MemW = 1'b0;
        chk("mid_cpu_reset2", {31'b0, cpu_reset}, 32'd1);
        chk("load_memw_cnt", {16'b0, st_cnt}, 32'd0);
        beat(1'b0, 32'hAAAA_0000, 1'b1);
        chk("mid_released", {31'b0, cpu_reset}, 32'd0);
        PC_out = 32'h0; #1;
        chk("mid_imem0", inst_in, 32'hAAAA_0000);
        PC_out = 32'h4; #1;
        chk("mid_imem1", inst_in, 32'h2222_2222);
        PC_out = 32'h8; #1;
        chk("mid_imem2", inst_in, 32'h0021_1820);
        PC_out = 32'h0;
        Addr_out = 32'h0; #1;
        chk("mid_dmem0", Data_in, 32'h0000_0001);

        // ---- LED register / MMIO address ----
        Addr_out = 32'hE000_0000; Data_out = 32'h0001_ABCD; MemW = 1'b1;
        tick();
        MemW = 1'b0; #1;
`ifdef SCPU_MMIO_LED_EN
        chk("led_value", {16'b0, led}, 32'h0000_ABCD);
        chk("led_load", Data_in, 32'h0000_ABCD);
        chk("led_cnt", {16'b0, st_cnt}, 32'd1);
        chk("led_no_err", {31'b0, addr_err}, 32'd0);
`else
        chk("mmio_oor_load", Data_in, 32'd0);
        chk("mmio_oor_cnt", {16'b0, st_cnt}, 32'd0);
        chk("mmio_oor_err", {31'b0, addr_err}, 32'd1);
`endif
        Addr_out = 32'h0;

        // ---- IMEM overflow ----
        do_reset();
        for (int i = 0; i < 128; i++) begin
            beat(1'b0, 32'h0000_0100 + i, 1'b0);
        end
        chk("ovf_not_yet", {31'b0, boot_ovf}, 32'd0);
        chk("ovf_still_load", {31'b0, ld_ready}, 32'd1);
        beat(1'b0, 32'hFFFF_FFFF, 1'b1);
        chk("ovf_set", {31'b0, boot_ovf}, 32'd1);
        chk("ovf_run", {31'b0, cpu_reset}, 32'd0);
        PC_out = 32'h0000_01FC; #1;
        chk("ovf_imem127", inst_in, 32'h0000_017F);
        PC_out = 32'h0; #1;
        chk("ovf_imem0", inst_in, 32'h0000_0100);
        chk("ovf_addr_err", {31'b0, addr_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
